// File: rtl/move_pkg.sv
// Shared move codes and capture FSM states for the gesture front end.
package move_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE     = 2'b00,
    MOVE_ROCK     = 2'b01,
    MOVE_PAPER    = 2'b10,
    MOVE_SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    ARMED,
    PRESENT
  } cap_state_t;

  // g is {scissors, paper, rock}; callers guarantee exactly one bit is set.
  function automatic move_t decode_gesture(input logic [2:0] g);
    case (g)
      3'b001:  return MOVE_ROCK;
      3'b010:  return MOVE_PAPER;
      3'b100:  return MOVE_SCISSORS;
      default: return MOVE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_capture_round_timer.sv
// round_timer: clearable up-counter that saturates at TIMEOUT_CYCLES-1 and
// flags that value as expired. Also used for scoring-phase timeouts.
module round_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturating at LAST means the counter can never wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/move_capture.sv
// move_capture: turns debounced rock/paper/scissors levels into one move per
// round. Optional reject counter enabled by defining MOVE_CAPTURE_STATS_EN.
module move_capture
  import move_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rock_on,
  input  logic       paper_on,
  input  logic       scissors_on,
  output logic [1:0] move,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       timed_out,
`ifdef MOVE_CAPTURE_STATS_EN
  output logic [7:0] reject_count,
`endif
  output logic       busy
);

  cap_state_t state_q, state_d;
  move_t      move_q, move_d;
  logic       valid_q, valid_d;
  logic       to_q, to_d;
  logic [2:0] prev_q;
  logic [2:0] cur;
  logic [2:0] rise;
  logic [1:0] pop;
  logic       single;
  logic       multi;
  logic       timer_clr;
  logic       timer_en;
  logic       expired;

  assign cur    = {scissors_on, paper_on, rock_on};
  assign rise   = cur & ~prev_q;
  assign pop    = 2'(cur[0]) + 2'(cur[1]) + 2'(cur[2]);
  assign single = (pop == 2'd1);
  assign multi  = (pop >= 2'd2);

  round_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      move_q  <= MOVE_NONE;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      prev_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      prev_q  <= cur;
    end
  end

  // Handshake: move/timed_out are valid and held stable while move_valid is
  // high; the result is consumed on the posedge where move_valid && move_ready.
  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    valid_d   = valid_q;
    to_d      = to_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (cur == 3'b000) begin
          state_d   = ARMED;
          timer_clr = 1'b1;
        end
      end
      ARMED: begin
        timer_en = 1'b1;
        // A fresh single gesture beats an expiry landing on the same cycle.
        if (single && (rise != 3'b000)) begin
          move_d  = decode_gesture(cur);
          valid_d = 1'b1;
          to_d    = 1'b0;
          state_d = PRESENT;
        end else if (!multi && expired) begin
          move_d  = MOVE_NONE;
          valid_d = 1'b1;
          to_d    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (valid_q && move_ready) begin
          valid_d = 1'b0;
          to_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MOVE_CAPTURE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_count <= 8'h00;
    end else if ((state_q == ARMED) && multi && (reject_count != 8'hFF)) begin
      reject_count <= reject_count + 8'd1;
    end
  end
`endif

  assign move       = move_q;
  assign move_valid = valid_q;
  assign timed_out  = to_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_move_capture.sv
// Self-checking bench for move_capture with TIMEOUT_CYCLES=8.
module tb_move_capture;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rock_on = 1'b0;
  logic       paper_on = 1'b0;
  logic       scissors_on = 1'b0;
  logic       move_ready = 1'b0;
  logic [1:0] move;
  logic       move_valid;
  logic       timed_out;
  logic       busy;
`ifdef MOVE_CAPTURE_STATS_EN
  logic [7:0] reject_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [2:0] gest;
    int         delay;
    logic [1:0] exp_move;
    logic       exp_to;
    int         hold;
  } vec_t;

  vec_t vecs[6];

  move_capture #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rock_on     (rock_on),
    .paper_on    (paper_on),
    .scissors_on (scissors_on),
    .move        (move),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .timed_out   (timed_out),
`ifdef MOVE_CAPTURE_STATS_EN
    .reject_count(reject_count),
`endif
    .busy        (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare each accepted result against the oldest expectation
  always @(negedge clk) begin
    if (!reset && move_valid && move_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got {to,move}=%0h with empty queue", {timed_out, move});
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({timed_out, move} !== e) begin
          n_fail++;
          $display("FAIL sb_result: got {to,move}=%0h expected %0h", {timed_out, move}, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_gest(input logic [2:0] g);
    {scissors_on, paper_on, rock_on} = g;
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    start = 1'b0;
    move_ready = 1'b0;
    set_gest(3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", move_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_move", move, 0);
`ifdef MOVE_CAPTURE_STATS_EN
    check("rst_reject_count", reject_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic accept(input logic [1:0] em);
    move_ready = 1'b1;
    set_gest(3'b000);
    tick;
    move_ready = 1'b0;
    check("acc_valid_low", move_valid, 0);
    check("acc_busy_low", busy, 0);
    check("acc_timed_out_low", timed_out, 0);
    check("acc_move_kept", move, em);
  endtask

  task automatic run_round(input vec_t v);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    tick;  // ARMED entered, timer=0
    if (!v.exp_to) begin
      repeat (v.delay) tick;
      set_gest(v.gest);
      check("no_early_valid", move_valid, 0);
      exp_q.push_back({v.exp_to, v.exp_move});
      tick;
    end else begin
      exp_q.push_back({v.exp_to, v.exp_move});
      for (int i = 0; i < TO; i++) begin
        check("timeout_not_early", move_valid, 0);
        tick;
      end
    end
    check("cap_valid", move_valid, 1);
    check("cap_move", move, v.exp_move);
    check("cap_timed_out", timed_out, v.exp_to);
    for (int i = 0; i < v.hold; i++) begin
      start = 1'b1;
      set_gest(3'($urandom_range(0, 7)));
      tick;
      check("hold_valid", move_valid, 1);
      check("hold_move", move, v.exp_move);
      check("hold_timed_out", timed_out, v.exp_to);
    end
    start = 1'b0;
    accept(v.exp_move);
  endtask

  initial begin
    vecs[0] = '{gest: 3'b010, delay: 3, exp_move: 2'b10, exp_to: 1'b0, hold: 3};
    vecs[1] = '{gest: 3'b001, delay: 0, exp_move: 2'b01, exp_to: 1'b0, hold: 0};
    vecs[2] = '{gest: 3'b100, delay: 5, exp_move: 2'b11, exp_to: 1'b0, hold: 1};
    vecs[3] = '{gest: 3'b000, delay: 0, exp_move: 2'b00, exp_to: 1'b1, hold: 2};
    vecs[4] = '{gest: 3'b001, delay: TO - 1, exp_move: 2'b01, exp_to: 1'b0, hold: 0};
    vecs[5] = '{gest: 3'b010, delay: TO - 2, exp_move: 2'b10, exp_to: 1'b0, hold: 1};

    reset_dut;
    for (int i = 0; i < 6; i++) run_round(vecs[i]);

    // stale hold: gesture held across start must not be captured
    set_gest(3'b001);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("stale_busy", busy, 1);
    repeat (3) begin
      tick;
      check("stale_no_valid", move_valid, 0);
    end
    set_gest(3'b010);
    tick;
    check("stale_swap_no_valid", move_valid, 0);
    tick;
    check("stale_swap_no_valid2", move_valid, 0);
    set_gest(3'b000);
    tick;
    set_gest(3'b100);
    exp_q.push_back({1'b0, 2'b11});
    tick;
    check("stale_cap_valid", move_valid, 1);
    check("stale_cap_move", move, 2'b11);
    check("stale_cap_to", timed_out, 0);
    accept(2'b11);

    // ambiguous multi-gesture input
    reset_dut;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    set_gest(3'b011);
    repeat (3) begin
      tick;
      check("amb_no_valid", move_valid, 0);
    end
`ifdef MOVE_CAPTURE_STATS_EN
    check("amb_reject_count", reject_count, 3);
`endif
    set_gest(3'b001);
    tick;
    check("amb_drop_no_valid", move_valid, 0);
    set_gest(3'b000);
    tick;
    set_gest(3'b001);
    exp_q.push_back({1'b0, 2'b01});
    tick;
    check("amb_cap_valid", move_valid, 1);
    check("amb_cap_move", move, 2'b01);
    check("amb_cap_to", timed_out, 0);
    accept(2'b01);
`ifdef MOVE_CAPTURE_STATS_EN
    check("amb_reject_hold", reject_count, 3);
`endif

    // async reset in PRESENT after a timeout, between clock edges
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    repeat (TO) tick;
    check("ar_pre_valid", move_valid, 1);
    check("ar_pre_to", timed_out, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid_drop", move_valid, 0);
    check("ar_busy_drop", busy, 0);
    check("ar_to_drop", timed_out, 0);
    check("ar_move_none", move, 0);
    @(negedge clk);
    reset = 1'b0;
    run_round(vecs[0]);

    repeat (2) tick;
    check("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
